// File: rtl/pipeline_stage_register.sv
// Elastic pipeline register: one main entry that drives the outputs plus one
// skid entry, with a valid/ready handshake and a synchronous flush.
// inReady depends only on the state register, so downstream backpressure
// never reaches upstream combinationally. outCtrl is forced to zero whenever
// outValid is low, so a bubble can never write the regfile or memory.
// Optional feature macro: PIPE_STAGE_STATS_EN adds the COUNT_WIDTH parameter
// and the stallCount/bubbleCount saturating statistics counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | nothing held, outValid=0, inReady=1
// ST_HALF  | main entry valid, skid free, outValid=1, inReady=1
// ST_FULL  | main and skid entries valid, outValid=1, inReady=0

module pipeline_stage_register #(
    parameter int PAYLOAD_WIDTH = 110,
    parameter int CTRL_WIDTH    = 6
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int COUNT_WIDTH   = 32
`endif
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [PAYLOAD_WIDTH-1:0] inPayload,
    input  logic [CTRL_WIDTH-1:0]    inCtrl,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [PAYLOAD_WIDTH-1:0] outPayload,
    output logic [CTRL_WIDTH-1:0]    outCtrl
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0]   stallCount,
    output logic [COUNT_WIDTH-1:0]   bubbleCount
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [PAYLOAD_WIDTH-1:0] r_main_payload;
    logic [CTRL_WIDTH-1:0]    r_main_ctrl;
    logic [PAYLOAD_WIDTH-1:0] r_skid_payload;
    logic [CTRL_WIDTH-1:0]    r_skid_ctrl;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign outValid   = (r_state != ST_EMPTY);
    assign inReady    = (r_state != ST_FULL);
    assign outPayload = r_main_payload;
    assign outCtrl    = r_main_ctrl & {CTRL_WIDTH{outValid}};

    assign w_in_xfer  = inValid && inReady;
    assign w_out_xfer = outValid && outReady;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and entry load selects; flush overrides every transfer.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_next_state   = ST_HALF;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_next_state   = ST_HALF;
                        w_load_main_in = 1'b1;
                    end else if (w_in_xfer) begin
                        w_next_state = ST_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_out_xfer) begin
                        w_next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        w_next_state     = ST_HALF;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // Main and skid entry storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_main_payload <= '0;
            r_main_ctrl    <= '0;
            r_skid_payload <= '0;
            r_skid_ctrl    <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_payload <= inPayload;
                r_main_ctrl    <= inCtrl;
            end else if (w_load_main_skid) begin
                r_main_payload <= r_skid_payload;
                r_main_ctrl    <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_payload <= inPayload;
                r_skid_ctrl    <= inCtrl;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [COUNT_WIDTH-1:0] r_stall_count;
    logic [COUNT_WIDTH-1:0] r_bubble_count;
    logic                   w_stall;
    logic                   w_bubble;

    assign w_stall     = outValid && !outReady;
    assign w_bubble    = !outValid;
    assign stallCount  = r_stall_count;
    assign bubbleCount = r_bubble_count;

    // Saturating statistics counters; only reset clears them, flush does not.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_count  <= '0;
            r_bubble_count <= '0;
        end else begin
            if (w_stall && (r_stall_count != {COUNT_WIDTH{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (w_bubble && (r_bubble_count != {COUNT_WIDTH{1'b1}})) begin
                r_bubble_count <= r_bubble_count + 1'b1;
            end
        end
    end
`endif

endmodule
